// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback merge stage and its source FIFOs.
package wb_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned NR_WB_SRC     = 5;

    // Result sources in fixed index order
    typedef enum logic [2:0] {
        FLU   = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        FPU   = 3'd3,
        CVXIF = 3'd4
    } wb_src_e;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        exception_t               ex;
        logic                     we;
    } wb_entry_t;

    // Round-robin candidate: source visited at 'offset' steps from 'ptr' within 1..4
    function automatic logic [2:0] rr_src(input logic [2:0] ptr, input logic [1:0] offset);
        logic [2:0] idx;
        idx = ptr + {1'b0, offset};
        if (idx > 3'd4) begin
            return idx - 3'd4;
        end else begin
            return idx;
        end
    endfunction

    // Pointer value following a grant to 'src', wrapping CVXIF back to LOAD
    function automatic logic [2:0] rr_next(input logic [2:0] src);
        if (src >= 3'd4) begin
            return 3'd1;
        end else begin
            return src + 3'd1;
        end
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO. When empty, an incoming entry is presented on the
// head in the same cycle so the arbiter can forward it without a bubble.
module wb_src_fifo
    import wb_pkg::*;
#(
    parameter int unsigned FifoDepth = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  logic      push_i,
    input  wb_entry_t data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      head_valid_o,
    output logic      almost_full_o,
    output logic      full_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    wb_entry_t       mem_r [FifoDepth];
    logic [PtrW-1:0] rd_ptr_r;
    logic [PtrW-1:0] wr_ptr_r;
    logic [CntW-1:0] count_r;
    logic            empty_s;
    logic            full_s;
    logic            do_write_s;
    logic            do_read_s;

    assign empty_s       = (count_r == CntW'(0));
    assign full_s        = (count_r == CntW'(FifoDepth));
    assign full_o        = full_s;
    assign almost_full_o = (count_r >= CntW'(FifoDepth - 1));

    // Head selection and push/pop qualification
    always_comb begin
        head_o       = mem_r[rd_ptr_r];
        head_valid_o = 1'b0;
        do_write_s   = 1'b0;
        do_read_s    = 1'b0;
        if (empty_s) begin
            head_o       = data_i;
            head_valid_o = push_i;
            // A bypassed entry consumed this cycle never lands in storage
            do_write_s   = push_i & ~pop_i;
        end else begin
            head_valid_o = 1'b1;
            do_read_s    = pop_i;
            // Full with a pop frees the head slot first, so the push still fits
            do_write_s   = push_i & (~full_s | pop_i);
        end
    end

    // Pointer and occupancy bookkeeping; flush discards stored and incoming entries
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_write_s) begin
                wr_ptr_r <= wr_ptr_r + PtrW'(1);
            end
            if (do_read_s) begin
                rd_ptr_r <= rd_ptr_r + PtrW'(1);
            end
            count_r <= count_r + CntW'(do_write_s) - CntW'(do_read_s);
        end
    end

    // Entry storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_write_s && !flush_i) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/wb_merge_stage.sv
// Collects execute-stage results into per-source FIFOs and merges them onto
// registered scoreboard writeback ports. FLU always owns port 0 when it has a
// result; the remaining ports are shared round-robin among LOAD..CVXIF.
module wb_merge_stage
    import wb_pkg::*;
#(
    parameter int unsigned NrWbPorts = 2,
    parameter int unsigned FifoDepth = 2,
    parameter int unsigned NrSrc     = NR_WB_SRC
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic [NrSrc-1:0]                          src_valid_i,
    input  logic [NrSrc-1:0][TRANS_ID_BITS-1:0]       src_trans_id_i,
    input  logic [NrSrc-1:0][XLEN-1:0]                src_result_i,
    input  exception_t [NrSrc-1:0]                    src_ex_i,
    input  logic                                      x_we_i,
    output logic [NrSrc-1:0]                          src_almost_full_o,
    output logic                                      overflow_o,
    output logic [NrWbPorts-1:0]                      wb_valid_o,
    output logic [NrWbPorts-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [NrWbPorts-1:0][XLEN-1:0]            wb_result_o,
    output exception_t [NrWbPorts-1:0]                wb_ex_o,
    output logic [NrWbPorts-1:0]                      wb_we_o
);

    localparam int unsigned PortIdxW = (NrWbPorts > 1) ? $clog2(NrWbPorts) : 1;
    localparam logic [2:0]  NR_PORTS = 3'(NrWbPorts);

    wb_entry_t                              push_entry_s [NrSrc];
    wb_entry_t                              head_s       [NrSrc];
    logic [NrSrc-1:0]                       head_valid_s;
    logic [NrSrc-1:0]                       full_s;
    logic [NrSrc-1:0]                       pop_s;
    logic [NrWbPorts-1:0]                   port_used_s;
    logic [2:0]                             port_src_s   [NrWbPorts];
    logic [2:0]                             rr_ptr_r;
    logic [2:0]                             rr_ptr_next_s;
    logic                                   overflow_hit_s;
    logic                                   overflow_r;
    logic [NrWbPorts-1:0]                   wb_valid_r;
    logic [NrWbPorts-1:0][TRANS_ID_BITS-1:0] wb_trans_id_r;
    logic [NrWbPorts-1:0][XLEN-1:0]         wb_result_r;
    exception_t [NrWbPorts-1:0]             wb_ex_r;
    logic [NrWbPorts-1:0]                   wb_we_r;

    for (genvar s = 0; s < int'(NrSrc); s++) begin : g_src
        logic we_s;

        // Register-file write enable carried by this source's results
        always_comb begin
            case (wb_src_e'(s))
                STORE:   we_s = 1'b0;
                CVXIF:   we_s = x_we_i;
                default: we_s = 1'b1;
            endcase
        end

        assign push_entry_s[s] = '{
            trans_id: src_trans_id_i[s],
            result:   src_result_i[s],
            ex:       src_ex_i[s],
            we:       we_s
        };

        wb_src_fifo #(
            .FifoDepth (FifoDepth)
        ) u_fifo (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .flush_i       (flush_i),
            .push_i        (src_valid_i[s]),
            .data_i        (push_entry_s[s]),
            .pop_i         (pop_s[s]),
            .head_o        (head_s[s]),
            .head_valid_o  (head_valid_s[s]),
            .almost_full_o (src_almost_full_o[s]),
            .full_o        (full_s[s])
        );
    end

    // Grant FLU first, then walk LOAD..CVXIF from the round-robin pointer
    always_comb begin
        logic [2:0] grants;
        logic [2:0] cand;
        pop_s         = '0;
        port_used_s   = '0;
        rr_ptr_next_s = rr_ptr_r;
        grants        = 3'd0;
        cand          = 3'd0;
        for (int k = 0; k < int'(NrWbPorts); k++) begin
            port_src_s[k] = 3'd0;
        end
        if (head_valid_s[FLU]) begin
            port_used_s[0] = 1'b1;
            port_src_s[0]  = FLU;
            pop_s[FLU]     = 1'b1;
            grants         = 3'd1;
        end else begin
            grants = 3'd0;
        end
        for (int i = 0; i < 4; i++) begin
            cand = rr_src(rr_ptr_r, 2'(i));
            if (head_valid_s[cand] && (grants < NR_PORTS)) begin
                port_used_s[grants[PortIdxW-1:0]] = 1'b1;
                port_src_s[grants[PortIdxW-1:0]]  = cand;
                pop_s[cand]                       = 1'b1;
                grants                            = grants + 3'd1;
                rr_ptr_next_s                     = rr_next(cand);
            end else begin
                grants = grants;
            end
        end
    end

    // A push that finds its FIFO full and not draining this cycle is lost
    assign overflow_hit_s = ~flush_i & (|(src_valid_i & full_s & ~pop_s));

    // Writeback port registers and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_r    <= '0;
            wb_trans_id_r <= '0;
            wb_result_r   <= '0;
            wb_ex_r       <= '0;
            wb_we_r       <= '0;
            rr_ptr_r      <= 3'd1;
        end else if (flush_i) begin
            wb_valid_r    <= '0;
            wb_trans_id_r <= '0;
            wb_result_r   <= '0;
            wb_ex_r       <= '0;
            wb_we_r       <= '0;
            rr_ptr_r      <= 3'd1;
        end else begin
            for (int k = 0; k < int'(NrWbPorts); k++) begin
                if (port_used_s[k]) begin
                    wb_valid_r[k]    <= 1'b1;
                    wb_trans_id_r[k] <= head_s[port_src_s[k]].trans_id;
                    wb_result_r[k]   <= head_s[port_src_s[k]].result;
                    wb_ex_r[k]       <= head_s[port_src_s[k]].ex;
                    wb_we_r[k]       <= head_s[port_src_s[k]].we;
                end else begin
                    wb_valid_r[k]    <= 1'b0;
                    wb_trans_id_r[k] <= '0;
                    wb_result_r[k]   <= '0;
                    wb_ex_r[k]       <= '0;
                    wb_we_r[k]       <= 1'b0;
                end
            end
            rr_ptr_r <= rr_ptr_next_s;
        end
    end

    // Sticky overflow flag; survives flush, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_r <= 1'b0;
        end else if (overflow_hit_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow_o    = overflow_r;
    assign wb_valid_o    = wb_valid_r;
    assign wb_trans_id_o = wb_trans_id_r;
    assign wb_result_o   = wb_result_r;
    assign wb_ex_o       = wb_ex_r;
    assign wb_we_o       = wb_we_r;

endmodule

// File: tb/tb_wb_merge_stage.sv
// Directed bench for wb_merge_stage with a writeback scoreboard.
module tb_wb_merge_stage;
    import wb_pkg::*;

    localparam int NP = 2;
    localparam int FD = 2;
    localparam int NS = 5;

    logic                               clk_i = 1'b0;
    logic                               rst_ni;
    logic                               flush_i;
    logic [NS-1:0]                      src_valid_i;
    logic [NS-1:0][TRANS_ID_BITS-1:0]   src_trans_id_i;
    logic [NS-1:0][XLEN-1:0]            src_result_i;
    exception_t [NS-1:0]                src_ex_i;
    logic                               x_we_i;
    logic [NS-1:0]                      src_almost_full_o;
    logic                               overflow_o;
    logic [NP-1:0]                      wb_valid_o;
    logic [NP-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o;
    logic [NP-1:0][XLEN-1:0]            wb_result_o;
    exception_t [NP-1:0]                wb_ex_o;
    logic [NP-1:0]                      wb_we_o;

    wb_merge_stage #(
        .NrWbPorts (NP),
        .FifoDepth (FD),
        .NrSrc     (NS)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .src_valid_i       (src_valid_i),
        .src_trans_id_i    (src_trans_id_i),
        .src_result_i      (src_result_i),
        .src_ex_i          (src_ex_i),
        .x_we_i            (x_we_i),
        .src_almost_full_o (src_almost_full_o),
        .overflow_o        (overflow_o),
        .wb_valid_o        (wb_valid_o),
        .wb_trans_id_o     (wb_trans_id_o),
        .wb_result_o       (wb_result_o),
        .wb_ex_o           (wb_ex_o),
        .wb_we_o           (wb_we_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int                       port;
        logic [TRANS_ID_BITS-1:0] id;
        logic [XLEN-1:0]          res;
        exception_t               ex;
        logic                     we;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   sb_en  = 1'b0;
    exception_t no_ex = '0;
    exception_t st_ex;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        src_valid_i    = '0;
        src_trans_id_i = '0;
        src_result_i   = '0;
        src_ex_i       = '0;
        x_we_i         = 1'b0;
    endtask

    task automatic pulse(input int s, input logic [TRANS_ID_BITS-1:0] id,
                         input logic [XLEN-1:0] res, input exception_t ex);
        src_valid_i[s]    = 1'b1;
        src_trans_id_i[s] = id;
        src_result_i[s]   = res;
        src_ex_i[s]       = ex;
    endtask

    task automatic expect_wb(input int port, input logic [TRANS_ID_BITS-1:0] id,
                             input logic [XLEN-1:0] res, input logic we, input exception_t ex);
        exp_t e;
        e.port = port; e.id = id; e.res = res; e.we = we; e.ex = ex;
        sb_q.push_back(e);
    endtask

    // Advance one edge, then score every valid writeback port in port order
    task automatic tick();
        exp_t e;
        @(posedge clk_i);
        #1;
        if (sb_en) begin
            for (int k = 0; k < NP; k++) begin
                if (wb_valid_o[k]) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_valid", 256'(wb_valid_o[k]), 256'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_port", 256'(k), 256'(e.port));
                        check("sb_trans_id", 256'(wb_trans_id_o[k]), 256'(e.id));
                        check("sb_result", 256'(wb_result_o[k]), 256'(e.res));
                        check("sb_we", 256'(wb_we_o[k]), 256'(e.we));
                        check("sb_ex", 256'(wb_ex_o[k]), 256'(e.ex));
                    end
                end
            end
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        clear_inputs();
        st_ex.cause = 64'd5;
        st_ex.tval  = 64'h1000;
        st_ex.valid = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_valid", 256'(wb_valid_o), 256'(0));
        check("rst_result", 256'(wb_result_o), 256'(0));
        check("rst_trans_id", 256'(wb_trans_id_o), 256'(0));
        check("rst_we", 256'(wb_we_o), 256'(0));
        check("rst_almost_full", 256'(src_almost_full_o), 256'(0));
        check("rst_overflow", 256'(overflow_o), 256'(0));
        rst_ni = 1'b1;
        sb_en  = 1'b1;
        tick();
        check("idle_valid", 256'(wb_valid_o), 256'(0));

        // Single LOAD pulse, visible one edge later on port 0
        pulse(1, 3'd3, 64'hDEADBEEF, no_ex);
        expect_wb(0, 3'd3, 64'hDEADBEEF, 1'b1, no_ex);
        tick();
        check("s1_valid", 256'(wb_valid_o), 256'(2'b01));
        clear_inputs();
        tick();
        check("s1_idle", 256'(wb_valid_o), 256'(0));

        // Flush returns the pointer to LOAD
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_idle", 256'(wb_valid_o), 256'(0));

        // FLU, LOAD, FPU together with two ports
        pulse(0, 3'd1, 64'h11, no_ex);
        pulse(1, 3'd2, 64'h22, no_ex);
        pulse(3, 3'd4, 64'h44, no_ex);
        expect_wb(0, 3'd1, 64'h11, 1'b1, no_ex);
        expect_wb(1, 3'd2, 64'h22, 1'b1, no_ex);
        expect_wb(0, 3'd4, 64'h44, 1'b1, no_ex);
        tick();
        check("s2_c1_valid", 256'(wb_valid_o), 256'(2'b11));
        clear_inputs();
        tick();
        check("s2_c2_valid", 256'(wb_valid_o), 256'(2'b01));
        tick();
        check("s2_c3_valid", 256'(wb_valid_o), 256'(0));

        // Pointer now at CVXIF: CVXIF beats LOAD, STORE waits a cycle
        pulse(1, 3'd5, 64'h55, no_ex);
        pulse(2, 3'd6, 64'h66, st_ex);
        pulse(4, 3'd7, 64'h77, no_ex);
        x_we_i = 1'b0;
        expect_wb(0, 3'd7, 64'h77, 1'b0, no_ex);
        expect_wb(1, 3'd5, 64'h55, 1'b1, no_ex);
        expect_wb(0, 3'd6, 64'h66, 1'b0, st_ex);
        tick();
        check("s3_c1_valid", 256'(wb_valid_o), 256'(2'b11));
        clear_inputs();
        tick();
        check("s3_c2_valid", 256'(wb_valid_o), 256'(2'b01));
        tick();
        check("s3_c3_valid", 256'(wb_valid_o), 256'(0));

        // Saturation: every source pulses for three cycles from a fresh pointer
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        sb_en   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < NS; s++) begin
                pulse(s, 3'(s), 64'(c * 16 + s), no_ex);
            end
            x_we_i = 1'b1;
            tick();
            check("sat_port0_result", 256'(wb_result_o[0]), 256'(c * 16));
            case (c)
                0: begin
                    check("sat_c0_port1", 256'(wb_result_o[1]), 256'(64'h01));
                    check("sat_c0_af", 256'(src_almost_full_o), 256'(5'b11100));
                    check("sat_c0_ovf", 256'(overflow_o), 256'(0));
                end
                1: begin
                    check("sat_c1_port1", 256'(wb_result_o[1]), 256'(64'h02));
                    check("sat_c1_af", 256'(src_almost_full_o), 256'(5'b11110));
                    check("sat_c1_ovf", 256'(overflow_o), 256'(0));
                end
                default: begin
                    check("sat_c2_port1", 256'(wb_result_o[1]), 256'(64'h03));
                    check("sat_c2_af", 256'(src_almost_full_o), 256'(5'b11110));
                    check("sat_c2_ovf", 256'(overflow_o), 256'(1));
                end
            endcase
            clear_inputs();
        end

        // Flush with buffered entries and a new FLU pulse in the same cycle
        flush_i = 1'b1;
        pulse(0, 3'd1, 64'h99, no_ex);
        tick();
        flush_i = 1'b0;
        clear_inputs();
        check("flush_valid", 256'(wb_valid_o), 256'(0));
        check("flush_af", 256'(src_almost_full_o), 256'(0));
        check("flush_ovf_sticky", 256'(overflow_o), 256'(1));
        tick();
        check("post_flush_valid", 256'(wb_valid_o), 256'(0));

        // Asynchronous reset in the middle of a burst
        for (int s = 0; s < NS; s++) begin
            pulse(s, 3'(s), 64'(8'hA0 + s), no_ex);
        end
        tick();
        check("burst_valid", 256'(wb_valid_o), 256'(2'b11));
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 256'(wb_valid_o), 256'(0));
        check("arst_result", 256'(wb_result_o), 256'(0));
        check("arst_af", 256'(src_almost_full_o), 256'(0));
        check("arst_ovf", 256'(overflow_o), 256'(0));
        clear_inputs();
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_valid", 256'(wb_valid_o), 256'(0));

        // Fresh LOAD pulse after reset
        sb_en = 1'b1;
        pulse(1, 3'd3, 64'hDEADBEEF, no_ex);
        expect_wb(0, 3'd3, 64'hDEADBEEF, 1'b1, no_ex);
        tick();
        check("s6_valid", 256'(wb_valid_o), 256'(2'b01));
        clear_inputs();
        tick();
        check("s6_idle", 256'(wb_valid_o), 256'(0));

        check("sb_drained", 256'(sb_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
